// File: rtl/p_cacheline_adaptor.sv
// Cache-line to burst adaptor: turns one held pmem line read/write into a
// BEATS-long burst on the narrow memory bus and pulses pmem_resp once.
module p_cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [31:0]            pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);
    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [31:0]            addr_reg, addr_next;
    logic                   load_line;
    logic                   store_beat;
    logic [BURST_WIDTH-1:0] beat_view [BEATS];
    logic [OFFSET_W-1:0]    unused_offset;

    assign unused_offset = pmem_address[OFFSET_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        load_line  = 1'b0;
        store_beat = 1'b0;
        read_o     = 1'b0;
        write_o    = 1'b0;
        pmem_resp  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Write wins when the requester raises both strobes.
                if (pmem_write) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                    addr_next  = {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                    load_line  = 1'b1;
                end else if (pmem_read) begin
                    state_next = READ;
                    cnt_next   = '0;
                    addr_next  = {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i) begin
                    store_beat = 1'b1;
                    if (cnt_reg == LAST) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (resp_i) begin
                    if (cnt_reg == LAST) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                pmem_resp  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One register per beat slice; each loads from the write line or from
    // the memory bus when the counter points at it.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            logic [BURST_WIDTH-1:0] beat_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    beat_reg <= '0;
                end else if (load_line) begin
                    beat_reg <= pmem_wdata[gi*BURST_WIDTH +: BURST_WIDTH];
                end else if (store_beat && (cnt_reg == CNT_W'(gi))) begin
                    beat_reg <= burst_i;
                end
            end

            assign beat_view[gi] = beat_reg;
            assign pmem_rdata[gi*BURST_WIDTH +: BURST_WIDTH] = beat_reg;
        end
    endgenerate

    assign address_o = addr_reg;
    assign burst_o   = (state_reg == WRITE) ? beat_view[cnt_reg] : '0;

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Self-checking bench for p_cacheline_adaptor: table-driven transactions,
// hand-written corner sequences and randomized bursts against a line model.
module tb_p_cacheline_adaptor;
    localparam int LW    = 256;
    localparam int BW    = 64;
    localparam int BEATS = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic [BW-1:0] burst_o;
    logic [BW-1:0] burst_i;
    logic          resp_i;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    bit            pat_q[$];
    logic [BW-1:0] beat_q[$];
    logic [BW-1:0] burst_log[$];
    int            last_active;
    int            last_resp_cyc;
    bit            have_line;
    logic [LW-1:0] last_line;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        bit          exp_rd;
        bit          exp_wr;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    p_cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .resp_i       (resp_i)
    );

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pmem_resp"}, 256'(pmem_resp), 256'(0));
        chk({tag, "_read_o"},    256'(read_o),    256'(0));
        chk({tag, "_write_o"},   256'(write_o),   256'(0));
        chk({tag, "_burst_o"},   256'(burst_o),   256'(0));
        chk({tag, "_address_o"}, 256'(address_o), 256'(0));
        chk({tag, "_rdata"},     pmem_rdata,      256'(0));
    endtask

    // Called at a sample point inside an IDLE cycle; returns at the sample
    // point of the IDLE cycle that follows the pmem_resp cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [LW-1:0] wdata, input logic [31:0] exp_addr,
                           input bit exp_rd, input bit exp_wr, input int stall_pct);
        logic [LW-1:0] exp_line;
        int  beats;
        int  active;
        bit  done;
        chk("idle_resp", 256'(pmem_resp), 256'(0));
        chk("idle_busy", 256'({read_o, write_o}), 256'(0));
        if (have_line) chk("rdata_hold", pmem_rdata, last_line);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        resp_i       = 1'($urandom_range(0, 1));
        burst_i      = rand_beat();
        exp_line     = '0;
        beats        = 0;
        active       = 0;
        done         = 1'b0;
        burst_log.delete();
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (beats < BEATS) begin
                chk("read_o",    256'(read_o),    256'(exp_rd));
                chk("write_o",   256'(write_o),   256'(exp_wr));
                chk("address_o", 256'(address_o), 256'(exp_addr));
                chk("busy_resp", 256'(pmem_resp), 256'(0));
                if (exp_wr) begin
                    chk("burst_o", 256'(burst_o), 256'(wdata[beats*BW +: BW]));
                    burst_log.push_back(burst_o);
                end
                active++;
                pmem_address = $urandom;
                pmem_wdata   = rand_line();
                if (pat_q.size() > 0) resp_i = pat_q.pop_front();
                else if (stall_pct == 0) resp_i = 1'b1;
                else resp_i = ($urandom_range(0, 99) >= stall_pct);
                if (resp_i && beat_q.size() > 0) burst_i = beat_q.pop_front();
                else burst_i = rand_beat();
                if (resp_i) begin
                    exp_line[beats*BW +: BW] = burst_i;
                    beats++;
                end
            end else begin
                chk("pmem_resp",  256'(pmem_resp), 256'(1));
                chk("done_read",  256'(read_o),    256'(0));
                chk("done_write", 256'(write_o),   256'(0));
                if (!exp_wr) chk("pmem_rdata", pmem_rdata, exp_line);
                done          = 1'b1;
                last_resp_cyc = cyc;
                pmem_read     = 1'b0;
                pmem_write    = 1'b0;
                resp_i        = 1'($urandom_range(0, 1));
            end
        end
        chk("txn_timeout", 256'(done), 256'(1));
        last_active = active;
        have_line   = !exp_wr;
        last_line   = exp_line;
        txn_no++;
        $display("txn %0d rd=%0d wr=%0d addr=%h busy_cycles=%0d resp_cycle=%0d",
                 txn_no, rd, wr, addr, active, last_resp_cyc);
        if (done) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] a, b, c, d;
        logic [BW-1:0] exp_burst [7];
        int sel;
        logic [31:0] ra;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'hABCD_0020, 32'hABCD_0020, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_001F, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0001, 32'h8000_0000, 1'b0, 1'b1};

        rst          = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_i      = '0;
        resp_i       = 1'b0;
        have_line    = 1'b0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Zero-stall transactions from the table.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                beat_q = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
            end
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, rand_line(),
                    vecs[i].exp_addr, vecs[i].exp_rd, vecs[i].exp_wr, 0);
            chk("nostall_busy_cycles", 256'(last_active), 256'(4));
            chk("nostall_resp_cycle",  256'(last_resp_cyc), 256'(5));
            if (i == 0) begin
                chk("plan_rdata", pmem_rdata,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
            end
        end

        // Write with stall pattern 1,0,1,0,0,1,1.
        a = 64'hAAAA_AAAA_0000_0001;
        b = 64'hBBBB_BBBB_0000_0002;
        c = 64'hCCCC_CCCC_0000_0003;
        d = 64'hDDDD_DDDD_0000_0004;
        exp_burst = '{a, b, b, c, c, c, d};
        pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_txn(1'b0, 1'b1, 32'h0000_2040, {d, c, b, a}, 32'h0000_2040, 1'b0, 1'b1, 0);
        chk("stall_busy_cycles", 256'(last_active), 256'(7));
        chk("stall_resp_cycle",  256'(last_resp_cyc), 256'(8));
        chk("stall_log_len", 256'(burst_log.size()), 256'(7));
        for (int i = 0; i < 7 && i < burst_log.size(); i++) begin
            chk($sformatf("stall_burst_%0d", i), 256'(burst_log[i]), 256'(exp_burst[i]));
        end

        // Spurious strobes while idle must not move the counter.
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = rand_beat();
            @(posedge clk);
            #1;
            chk("spurious_read_o", 256'(read_o), 256'(0));
            chk("spurious_resp",   256'(pmem_resp), 256'(0));
        end
        run_txn(1'b1, 1'b0, 32'h0000_3000, rand_line(), 32'h0000_3000, 1'b1, 1'b0, 0);

        // Reset in the middle of a read after two beats.
        pmem_read    = 1'b1;
        pmem_address = 32'h4000_0040;
        resp_i       = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_read_o", 256'(read_o), 256'(1));
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = rand_beat();
            @(posedge clk);
            #1;
        end
        chk("rst_pre_read_o", 256'(read_o), 256'(1));
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        pmem_read = 1'b0;
        resp_i    = 1'b0;
        have_line = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_resp", 256'(pmem_resp), 256'(0));
            chk("rst_hold_read", 256'(read_o), 256'(0));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 32'h4000_0040, rand_line(), 32'h4000_0040, 1'b1, 1'b0, 25);

        // Back-to-back read then write.
        run_txn(1'b1, 1'b0, 32'h0000_5060, rand_line(), 32'h0000_5060, 1'b1, 1'b0, 0);
        run_txn(1'b0, 1'b1, 32'h0000_6080, rand_line(), 32'h0000_6080, 1'b0, 1'b1, 0);

        // Random traffic with stalls.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            ra  = $urandom;
            run_txn(sel != 1, sel != 0, ra, rand_line(), ra & ~32'h1F,
                    sel == 0, sel != 0, 30);
        end

        @(posedge clk);
        #1;
        chk("final_idle_resp", 256'(pmem_resp), 256'(0));
        chk("final_idle_busy", 256'({read_o, write_o}), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
